fc_layer_sequencer: RTL and testbench

- Sequences a chain of NUM_LAYERS fully-connected layer engines that share one single-port activation/weight memory.
- Grants the memory port to exactly one layer engine at a time and drives that engine's enable.
- Relocates the engine's local addresses into a per-layer memory region, so each layer's outputs land where the next layer reads its inputs.
- Sits between the top-level CNN control (start/done) and the FC layer instances.

---
 rtl/fc_seq_pkg.sv | 19 +
 rtl/fc_layer_sequencer_if.sv | 40 ++++
 rtl/fc_port_mux.sv | 40 ++++
 rtl/fc_layer_sequencer.sv | 139 +++++++++++++
 tb/tb_fc_layer_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the FC layer sequencer:
// FSM state encoding, data width and per-layer region base computation.
package fc_seq_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  // Base address of memory region k; the caller truncates to its address width.
  function automatic logic [31:0] region_base(input int unsigned k, input int unsigned words);
    return k * words;
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Bundle of control, engine-side and memory-side signals of the FC layer sequencer.
// master: the sequencer itself; slave: the surrounding control/engines/memory.
interface fc_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = 16
);
  import fc_seq_pkg::*;

  // top-level control
  logic                         start;
  logic                         abort;
  // engine side
  logic [NUM_LAYERS-1:0]        eng_layer_end;
  logic [NUM_LAYERS-1:0]        eng_com_end;
  logic [NUM_LAYERS-1:0]        eng_we;
  logic [NUM_LAYERS*ADDR_W-1:0] eng_addr;
  logic [NUM_LAYERS*DATA_W-1:0] eng_out;
  logic [NUM_LAYERS-1:0]        eng_en;
  // shared memory port
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  // status
  logic [2:0]                   cur_layer;
  logic                         busy;
  logic                         done;
  logic                         error;
  logic [NUM_LAYERS-1:0]        com_end_sts;

  modport master (
    input  start, abort, eng_layer_end, eng_com_end, eng_we, eng_addr, eng_out,
    output eng_en, mem_we, mem_addr, mem_wdata, cur_layer, busy, done, error, com_end_sts
  );

  modport slave (
    output start, abort, eng_layer_end, eng_com_end, eng_we, eng_addr, eng_out,
    input  eng_en, mem_we, mem_addr, mem_wdata, cur_layer, busy, done, error, com_end_sts
  );

endinterface

// File: rtl/fc_port_mux.sv
// Selects the active engine's memory port by layer index and relocates its
// local address: reads come from region k, writes land in region k+1.
module fc_port_mux
  import fc_seq_pkg::*;
#(
  parameter int NUM_LAYERS   = 3,
  parameter int REGION_WORDS = 1024,
  parameter int ADDR_W       = 16
) (
  input  logic [2:0]                   sel_i,
  input  logic [NUM_LAYERS-1:0]        we_i,
  input  logic [NUM_LAYERS-1:0]        end_i,
  input  logic [NUM_LAYERS*ADDR_W-1:0] addr_i,
  input  logic [NUM_LAYERS*DATA_W-1:0] out_i,
  output logic                         we_o,
  output logic                         end_o,
  output logic [ADDR_W-1:0]            addr_o,
  output logic [DATA_W-1:0]            wdata_o
);

  // Combinational select; the relocated sum wraps silently at ADDR_W bits.
  always_comb begin
    logic [31:0] base;
    base    = '0;
    we_o    = 1'b0;
    end_o   = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (sel_i == 3'(k)) begin
        base    = region_base(we_i[k] ? k + 1 : k, REGION_WORDS);
        we_o    = we_i[k];
        end_o   = end_i[k];
        addr_o  = addr_i[k*ADDR_W +: ADDR_W] + base[ADDR_W-1:0];
        wdata_o = out_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Runs a chain of FC layer engines one at a time over a shared single-port
// memory: enables one engine, routes its port, inserts one dead cycle between
// layers and pulses done after the last one. Abort returns to IDLE with error.
// Optional build macro FC_SEQ_WATCHDOG_EN adds a per-layer RUN timeout that
// behaves like an abort.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int NUM_LAYERS   = 3,
  parameter int REGION_WORDS = 1024,
  parameter int ADDR_W       = 16,
  parameter int TIMEOUT_CYC  = 65535
) (
  input logic                 clk,
  input logic                 reset_n,
  fc_layer_sequencer_if.master bus
);

  seq_state_e              state_q;
  logic [NUM_LAYERS-1:0]   eng_en_q;
  logic [NUM_LAYERS-1:0]   com_end_q;
  logic [2:0]              cur_layer_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;

  logic                    sel_we;
  logic                    sel_end;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;
  logic                    run;
  logic                    last_layer;
  logic                    wd_expire;

  fc_port_mux #(
    .NUM_LAYERS  (NUM_LAYERS),
    .REGION_WORDS(REGION_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_port_mux (
    .sel_i  (cur_layer_q),
    .we_i   (bus.eng_we),
    .end_i  (bus.eng_layer_end),
    .addr_i (bus.eng_addr),
    .out_i  (bus.eng_out),
    .we_o   (sel_we),
    .end_o  (sel_end),
    .addr_o (sel_addr),
    .wdata_o(sel_wdata)
  );

  assign run        = (state_q == RUN);
  assign last_layer = (cur_layer_q == 3'(NUM_LAYERS - 1));

`ifdef FC_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  assign wd_expire = run && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // Per-layer RUN cycle counter; held at zero outside RUN so each layer starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  wd_q <= '0;
    else if (!run) wd_q <= '0;
    else           wd_q <= wd_q + WD_W'(1);
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Sequencing FSM with registered enables and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      eng_en_q    <= '0;
      com_end_q   <= '0;
      cur_layer_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= RUN;
            cur_layer_q <= '0;
            eng_en_q    <= NUM_LAYERS'(1);
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            com_end_q   <= '0;
          end
        end
        RUN: begin
          com_end_q <= com_end_q | (bus.eng_com_end & eng_en_q);
          if (bus.abort || wd_expire) begin
            state_q  <= IDLE;
            eng_en_q <= '0;
            busy_q   <= 1'b0;
            error_q  <= 1'b1;
          end else if (sel_end) begin
            state_q  <= RELEASE;
            eng_en_q <= '0;
          end
        end
        RELEASE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (last_layer) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= RUN;
            cur_layer_q <= cur_layer_q + 3'd1;
            eng_en_q    <= NUM_LAYERS'(1) << (cur_layer_q + 3'd1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port is live only in RUN; all other states park it at zero.
  assign bus.mem_we      = run & sel_we;
  assign bus.mem_addr    = run ? sel_addr : '0;
  assign bus.mem_wdata   = run ? sel_wdata : '0;
  assign bus.eng_en      = eng_en_q;
  assign bus.cur_layer   = cur_layer_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.com_end_sts = com_end_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: reset state, full auto-ended run,
// table of port mux/relocation vectors, abort, watchdog and async reset.
module tb_fc_layer_sequencer;

  localparam int NL = 3;
  localparam int AW = 16;

  typedef struct {
    int             layer;
    logic [NL-1:0]  we;
    logic [NL*AW-1:0] addr;
    logic [NL*16-1:0] out;
    logic           exp_we;
    logic [AW-1:0]  exp_addr;
    logic [15:0]    exp_wdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [NL-1:0] man_end;
  logic [NL-1:0] auto_end;
  logic          auto_mode;
  logic [7:0]    stub_cnt [NL];
  vec_t          vecs [10];

  fc_layer_sequencer_if #(.NUM_LAYERS(NL), .ADDR_W(AW)) bus();

  fc_layer_sequencer #(
    .NUM_LAYERS  (NL),
    .REGION_WORDS(1024),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Stub engines: raise layer_end after 10 enabled cycles when auto_mode is on.
  for (genvar gi = 0; gi < NL; gi++) begin : g_stub
    always @(posedge clk) begin
      if (bus.eng_en[gi]) stub_cnt[gi] <= stub_cnt[gi] + 8'd1;
      else                stub_cnt[gi] <= 8'd0;
    end
    assign auto_end[gi] = auto_mode & bus.eng_en[gi] & (stub_cnt[gi] >= 8'd10);
  end

  assign bus.eng_layer_end = auto_end | man_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Leaves the caller at the negedge of the first RUN cycle.
  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  // Ends layer k (called at a RUN negedge); checks the dead cycle on the way.
  task automatic end_layer(input int k);
    man_end[k] = 1'b1;
    @(negedge clk);
    man_end = '0;
    bus.eng_we = '1;
    #1;
    chk("release_en", 32'(bus.eng_en), 32'h0);
    chk("release_mem_we", 32'(bus.mem_we), 32'h0);
    chk("release_busy", 32'(bus.busy), 32'h1);
    bus.eng_we = '0;
    @(negedge clk);
  endtask

  function automatic logic [4:0] trace_exp(input int i);
    logic [2:0] en;
    en = 3'b000;
    if (i <= 10)                en = 3'b001;
    else if (i >= 12 && i <= 22) en = 3'b010;
    else if (i >= 24 && i <= 34) en = 3'b100;
    return {en, (i == 36), (i <= 36)};
  endfunction

  // Full run with stub engines; optionally pulses start inside RUN.
  task automatic run_trace(input bit extra);
    logic [4:0] got;
    int dones;
    dones = 0;
    auto_mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      got = {bus.eng_en, bus.done, bus.busy};
      if (bus.done) dones++;
      chk($sformatf("trace%0d[%0d]", extra, i), 32'(got), 32'(trace_exp(i)));
      if (i == 36) chk("trace_cur_layer", 32'(bus.cur_layer), 32'd2);
      bus.start = extra && (i == 3 || i == 15 || i == 27);
      @(negedge clk);
    end
    bus.start = 1'b0;
    auto_mode = 1'b0;
    chk("trace_done_count", 32'(dones), 32'd1);
    $display("trace run extra_start=%0d done pulses=%0d", extra, dones);
  endtask

  initial begin
    int cur;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.eng_com_end = '0;
    bus.eng_we = '0;
    bus.eng_addr = {16'h0123, 16'h0456, 16'h0789};
    bus.eng_out = '0;
    man_end = '0;
    auto_mode = 1'b0;

    vecs[0] = '{0, 3'b000, {16'h0200, 16'h0100, 16'h0003}, {16'h3333, 16'h2222, 16'h1111}, 1'b0, 16'h0003, 16'h1111};
    vecs[1] = '{0, 3'b100, {16'h0200, 16'h0100, 16'h0010}, {16'hAAAA, 16'h2222, 16'h1111}, 1'b0, 16'h0010, 16'h1111};
    vecs[2] = '{0, 3'b001, {16'h0200, 16'h0100, 16'h0020}, {16'h3333, 16'h2222, 16'hBEEF}, 1'b1, 16'h0420, 16'hBEEF};
    vecs[3] = '{1, 3'b000, {16'h0200, 16'h0005, 16'h0003}, {16'h3333, 16'h2222, 16'h1111}, 1'b0, 16'h0405, 16'h2222};
    vecs[4] = '{1, 3'b010, {16'h0200, 16'h0007, 16'h0003}, {16'h3333, 16'h1234, 16'h1111}, 1'b1, 16'h0807, 16'h1234};
    vecs[5] = '{1, 3'b101, {16'h0200, 16'h0009, 16'h0003}, {16'h3333, 16'h2222, 16'h1111}, 1'b0, 16'h0409, 16'h2222};
    vecs[6] = '{2, 3'b000, {16'h0001, 16'h0100, 16'h0003}, {16'h3333, 16'h2222, 16'h1111}, 1'b0, 16'h0801, 16'h3333};
    vecs[7] = '{2, 3'b100, {16'hF000, 16'h0100, 16'h0003}, {16'h5555, 16'h2222, 16'h1111}, 1'b1, 16'hFC00, 16'h5555};
    vecs[8] = '{2, 3'b011, {16'hFC00, 16'h0100, 16'h0003}, {16'h3333, 16'h2222, 16'h1111}, 1'b0, 16'h0400, 16'h3333};
    vecs[9] = '{2, 3'b100, {16'hFFFF, 16'h0100, 16'h0003}, {16'h0001, 16'h2222, 16'h1111}, 1'b1, 16'h0BFF, 16'h0001};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_eng_en", 32'(bus.eng_en), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_status", 32'({bus.cur_layer, bus.busy, bus.done, bus.error}), 32'h0);
    reset_n = 1'b1;

    // abort in IDLE is ignored
    @(negedge clk) bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    chk("abort_idle_error", 32'(bus.error), 32'h0);
    chk("abort_idle_busy", 32'(bus.busy), 32'h0);

    run_trace(1'b0);
    run_trace(1'b1);

    // Port mux / relocation table
    bus.eng_we = '0;
    pulse_start();
    cur = 0;
    for (int v = 0; v < 10; v++) begin
      while (cur < vecs[v].layer) begin
        end_layer(cur);
        cur++;
      end
      bus.eng_we = vecs[v].we;
      bus.eng_addr = vecs[v].addr;
      bus.eng_out = vecs[v].out;
      #1;
      chk($sformatf("vec%0d_mem_we", v), 32'(bus.mem_we), 32'(vecs[v].exp_we));
      chk($sformatf("vec%0d_mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].exp_addr));
      chk($sformatf("vec%0d_mem_wdata", v), 32'(bus.mem_wdata), 32'(vecs[v].exp_wdata));
      chk($sformatf("vec%0d_eng_en", v), 32'(bus.eng_en), 32'(3'b001 << vecs[v].layer));
      chk($sformatf("vec%0d_cur_layer", v), 32'(bus.cur_layer), 32'(vecs[v].layer));
      $display("vec %0d layer %0d mem_we=%0b mem_addr=%h mem_wdata=%h", v, vecs[v].layer,
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
      @(negedge clk);
    end
    bus.eng_we = '0;
    end_layer(2);
    chk("mux_done", 32'({bus.done, bus.busy}), 32'b11);
    chk("mux_done_layer", 32'(bus.cur_layer), 32'd2);
    @(negedge clk);
    chk("mux_after_done", 32'({bus.done, bus.busy}), 32'b00);

    // Abort four cycles into layer 1, together with layer_end (abort wins)
    pulse_start();
    end_layer(0);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    man_end[1] = 1'b1;
    bus.eng_we = 3'b010;
    @(negedge clk);
    bus.abort = 1'b0;
    man_end = '0;
    chk("abort_eng_en", 32'(bus.eng_en), 32'h0);
    chk("abort_error", 32'(bus.error), 32'h1);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_mem_we", 32'(bus.mem_we), 32'h0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (bus.done || bus.eng_en != 3'b000) seen++;
        @(negedge clk);
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end
    bus.eng_we = '0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("restart_eng_en", 32'(bus.eng_en), 32'h1);
    chk("restart_error", 32'(bus.error), 32'h0);
    chk("restart_layer", 32'(bus.cur_layer), 32'h0);
    chk("restart_busy", 32'(bus.busy), 32'h1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;

    // Engine that never ends
    pulse_start();
    for (int i = 0; i <= 20; i++) begin
`ifdef FC_SEQ_WATCHDOG_EN
      if (i == 19) chk("wd_before_en", 32'(bus.eng_en), 32'h1);
      if (i == 20) begin
        chk("wd_expire_en", 32'(bus.eng_en), 32'h0);
        chk("wd_expire_error", 32'(bus.error), 32'h1);
        chk("wd_expire_busy", 32'(bus.busy), 32'h0);
      end
`else
      if (i == 20) begin
        chk("nowd_still_run", 32'(bus.eng_en), 32'h1);
        chk("nowd_error", 32'(bus.error), 32'h0);
      end
`endif
      if (i < 20) @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;

    // Asynchronous reset in the middle of a layer
    pulse_start();
    bus.eng_we = 3'b001;
    @(negedge clk);
    chk("pre_reset_mem_we", 32'(bus.mem_we), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(bus.eng_en), 32'h0);
    chk("async_rst_busy", 32'(bus.busy), 32'h0);
    chk("async_rst_mem_we", 32'(bus.mem_we), 32'h0);
    @(negedge clk);
    bus.eng_we = '0;
    reset_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
